// File: rtl/tiled_layer.sv
`default_nettype none
// ============================================================================
//  Module      : tiled_layer
//  Description : Time-multiplexed linear layer. Evaluates NUM_NEURONS neurons
//                on NUM_ALUS MAC lanes in tiles of NUM_ALUS. The input vector
//                is streamed in once (tile 0), buffered, and replayed for the
//                remaining tiles. One result word per tile is emitted under a
//                valid/ready handshake.
//  Options     : `define LAYER_RELU_EN to clamp negative lane results to zero
//                when they are latched for output (same latency either way).
//  Revision    : 1.0 - initial release
// ============================================================================
module tiled_layer #(
    parameter int NUM_NEURONS = 8,
    parameter int NUM_ALUS    = 4,
    parameter int NUM_INPUTS  = 4,
    parameter int BIT_WIDTH   = 32,
    parameter int EXTRA_BITS  = 2,
    parameter int ALU_LAT     = 1,
    localparam int W          = BIT_WIDTH + EXTRA_BITS,
    localparam int NUM_TILES  = (NUM_NEURONS + NUM_ALUS - 1) / NUM_ALUS,
    localparam int AW         = (NUM_TILES * NUM_INPUTS > 1) ? $clog2(NUM_TILES * NUM_INPUTS) : 1,
    localparam int TW         = (NUM_TILES > 1) ? $clog2(NUM_TILES) : 1
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic                  START,
    input  logic [W-1:0]          IN_DATA,
    input  logic                  IN_VALID,
    output logic                  IN_READY,
    output logic [AW-1:0]         W_ADDR,
    input  logic [W*NUM_ALUS-1:0] W_DATA,
    output logic [W*NUM_ALUS-1:0] OUT_DATA,
    output logic [TW-1:0]         OUT_TILE,
    output logic                  OUT_VALID,
    input  logic                  OUT_READY,
    output logic                  BUSY,
    output logic                  DONE
);

    // Float field layout: {exc(EXTRA_BITS), sign, exponent(EW), fraction(MW)}
    localparam int EW   = (BIT_WIDTH == 64) ? 11 : ((BIT_WIDTH == 16) ? 5 : 8);
    localparam int MW   = BIT_WIDTH - 1 - EW;
    localparam int BIAS = (1 << (EW - 1)) - 1;
    localparam int EMAX = (1 << EW) - 2;
    localparam int PW   = 2 * MW + 2;
    localparam int GW   = 3;
    localparam int SW   = MW + 1 + GW;
    localparam int IW   = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;
    localparam int DCW  = $clog2(ALU_LAT + 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_REPLAY = 3'd2,
        S_DRAIN  = 3'd3,
        S_OUTPUT = 3'd4
    } state_t;

    // ------------------------------------------------------------------
    // Truncating float arithmetic: denormals flush to zero, overflow
    // saturates to the largest finite magnitude.
    // ------------------------------------------------------------------
    function automatic logic fp_zero(input logic [W-1:0] v);
        logic [1:0] exc;
        exc = 2'(v >> BIT_WIDTH);
        if (EXTRA_BITS == 2) return (exc == 2'b00);
        return (v[BIT_WIDTH-2:MW] == '0);
    endfunction

    function automatic logic [W-1:0] fp_pack(input logic s, input int e, input logic [MW-1:0] f);
        logic [W-1:0] r;
        r = '0;
        if (e <= 0) return r;
        if (e > EMAX) r[BIT_WIDTH-1:0] = {s, EW'(EMAX), {MW{1'b1}}};
        else          r[BIT_WIDTH-1:0] = {s, EW'(e), f};
        if (EXTRA_BITS == 2) r = r | (W'(1) << BIT_WIDTH);
        return r;
    endfunction

    function automatic logic [W-1:0] fp_mul(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [PW-1:0] p;
        logic          s;
        int            e;
        if (fp_zero(a) || fp_zero(b)) return '0;
        s = a[BIT_WIDTH-1] ^ b[BIT_WIDTH-1];
        p = PW'({1'b1, a[MW-1:0]}) * PW'({1'b1, b[MW-1:0]});
        e = int'(a[BIT_WIDTH-2:MW]) + int'(b[BIT_WIDTH-2:MW]) - BIAS;
        if (p[PW-1]) return fp_pack(s, e + 1, MW'(p >> (MW + 1)));
        return fp_pack(s, e, MW'(p >> MW));
    endfunction

    function automatic logic [W-1:0] fp_add(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [BIT_WIDTH-1:0] big, sml;
        logic [SW:0]          mb, ms, sum;
        int                   eb, sh;
        if (fp_zero(a)) return b;
        if (fp_zero(b)) return a;
        // Larger magnitude first so the subtraction never goes negative
        if (a[BIT_WIDTH-2:0] >= b[BIT_WIDTH-2:0]) begin
            big = a[BIT_WIDTH-1:0];
            sml = b[BIT_WIDTH-1:0];
        end else begin
            big = b[BIT_WIDTH-1:0];
            sml = a[BIT_WIDTH-1:0];
        end
        eb  = int'(big[BIT_WIDTH-2:MW]);
        sh  = eb - int'(sml[BIT_WIDTH-2:MW]);
        mb  = {2'b01, big[MW-1:0], {GW{1'b0}}};
        ms  = {2'b01, sml[MW-1:0], {GW{1'b0}}};
        ms  = (sh > SW) ? '0 : (ms >> sh);
        if (big[BIT_WIDTH-1] == sml[BIT_WIDTH-1]) begin
            sum = mb + ms;
            if (sum[SW]) begin
                sum = sum >> 1;
                eb  = eb + 1;
            end
        end else begin
            sum = mb - ms;
            if (sum == '0) return '0;
            for (int i = 0; i < SW; i++) begin
                if (!sum[SW-1]) begin
                    sum = sum << 1;
                    eb  = eb - 1;
                end
            end
        end
        return fp_pack(big[BIT_WIDTH-1], eb, MW'(sum >> GW));
    endfunction

    function automatic logic [W-1:0] fp_mac(input logic [W-1:0] acc, input logic [W-1:0] w,
                                            input logic [W-1:0] x, input logic en);
        logic [W-1:0] p;
        p = fp_mul(w, x);
        return en ? fp_add(acc, p) : p;
    endfunction

    // ------------------------------------------------------------------
    // Control state
    // ------------------------------------------------------------------
    state_t                r_state;
    logic [IW-1:0]         r_idx;
    logic [TW-1:0]         r_tile;
    logic [DCW-1:0]        r_drain;
    logic                  r_in_ready;
    logic                  r_out_valid;
    logic                  r_busy;
    logic                  r_done;
    logic [TW-1:0]         r_out_tile;
    logic [W*NUM_ALUS-1:0] r_out_data;

    // Operand pipeline (one stage, aligned with the synchronous weight read)
    logic [W-1:0]          r_buf [NUM_INPUTS];
    logic [W-1:0]          r_x_d;
    logic                  r_vld_d;
    logic                  r_acc_en_d;
    logic [AW-1:0]         r_w_addr;

    logic                  w_load_fire;
    logic                  w_issue;
    logic                  w_last_idx;
    logic [AW-1:0]         w_rd_addr;
    logic [W*NUM_ALUS-1:0] w_out_next;

    assign w_load_fire = r_in_ready & IN_VALID;
    assign w_issue     = w_load_fire | (r_state == S_REPLAY);
    assign w_last_idx  = (r_idx == IW'(NUM_INPUTS - 1));
    assign w_rd_addr   = AW'(32'(r_tile) * NUM_INPUTS + 32'(r_idx));

    // Address is presented in the issue cycle so weights land alongside r_x_d
    assign W_ADDR    = w_issue ? w_rd_addr : r_w_addr;
    assign IN_READY  = r_in_ready;
    assign OUT_VALID = r_out_valid;
    assign OUT_DATA  = r_out_data;
    assign OUT_TILE  = r_out_tile;
    assign BUSY      = r_busy;
    assign DONE      = r_done;

    // Sequencer: load / replay / drain / output with registered handshake outputs
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_state     <= S_IDLE;
            r_idx       <= '0;
            r_tile      <= '0;
            r_drain     <= '0;
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_out_tile  <= '0;
            r_out_data  <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (START) begin
                        r_state    <= S_LOAD;
                        r_tile     <= '0;
                        r_idx      <= '0;
                        r_in_ready <= 1'b1;
                        r_busy     <= 1'b1;
                    end
                end
                S_LOAD: begin
                    if (w_load_fire) begin
                        if (w_last_idx) begin
                            r_idx      <= '0;
                            r_drain    <= '0;
                            r_in_ready <= 1'b0;
                            r_state    <= S_DRAIN;
                        end else begin
                            r_idx <= r_idx + IW'(1);
                        end
                    end
                end
                S_REPLAY: begin
                    if (w_last_idx) begin
                        r_idx   <= '0;
                        r_drain <= '0;
                        r_state <= S_DRAIN;
                    end else begin
                        r_idx <= r_idx + IW'(1);
                    end
                end
                S_DRAIN: begin
                    // One cycle for the operand stage plus the ALU latency
                    if (r_drain == DCW'(ALU_LAT)) begin
                        r_out_data  <= w_out_next;
                        r_out_tile  <= r_tile;
                        r_out_valid <= 1'b1;
                        r_state     <= S_OUTPUT;
                    end else begin
                        r_drain <= r_drain + DCW'(1);
                    end
                end
                S_OUTPUT: begin
                    if (OUT_READY) begin
                        r_out_valid <= 1'b0;
                        if (r_tile == TW'(NUM_TILES - 1)) begin
                            r_done  <= 1'b1;
                            r_busy  <= 1'b0;
                            r_state <= S_IDLE;
                        end else begin
                            r_tile  <= r_tile + TW'(1);
                            r_idx   <= '0;
                            r_state <= S_REPLAY;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Input buffer written once during tile 0, replayed for later tiles
    always_ff @(posedge CLK) begin
        if (w_load_fire) r_buf[r_idx] <= IN_DATA;
    end

    // Operand stage and weight-address hold register
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_x_d      <= '0;
            r_vld_d    <= 1'b0;
            r_acc_en_d <= 1'b0;
            r_w_addr   <= '0;
        end else begin
            r_vld_d <= w_issue;
            if (w_issue) begin
                r_x_d      <= (r_state == S_LOAD) ? IN_DATA : r_buf[r_idx];
                r_acc_en_d <= (r_idx != '0);
                r_w_addr   <= w_rd_addr;
            end
        end
    end

    // ------------------------------------------------------------------
    // MAC lanes
    // ------------------------------------------------------------------
    for (genvar k = 0; k < NUM_ALUS; k++) begin : g_lane
        logic         w_act;
        logic [W-1:0] w_wgt;
        logic [W-1:0] w_res;
        logic [W-1:0] r_acc;

        // Lanes beyond NUM_NEURONS in the last tile see a zero weight
        assign w_act = (32'(r_tile) * NUM_ALUS + k) < NUM_NEURONS;
        assign w_wgt = w_act ? W_DATA[k*W +: W] : '0;

        // Accumulator: restart on the first input of a tile, accumulate otherwise
        always_ff @(posedge CLK or negedge RESET) begin
            if (!RESET) r_acc <= '0;
            else if (r_vld_d) r_acc <= fp_mac(r_acc, w_wgt, r_x_d, r_acc_en_d & w_act);
        end

        if (ALU_LAT > 1) begin : g_dly
            logic [W-1:0] r_dly [ALU_LAT-1];
            // Extra result stages so ACC_RESULT appears ALU_LAT cycles after the operands
            always_ff @(posedge CLK or negedge RESET) begin
                if (!RESET) begin
                    for (int i = 0; i < ALU_LAT - 1; i++) r_dly[i] <= '0;
                end else begin
                    r_dly[0] <= r_acc;
                    for (int i = 1; i < ALU_LAT - 1; i++) r_dly[i] <= r_dly[i-1];
                end
            end
            assign w_res = r_dly[ALU_LAT-2];
        end else begin : g_nodly
            assign w_res = r_acc;
        end

`ifdef LAYER_RELU_EN
        assign w_out_next[k*W +: W] = (w_act && !w_res[BIT_WIDTH-1]) ? w_res : '0;
`else
        assign w_out_next[k*W +: W] = w_act ? w_res : '0;
`endif
    end

endmodule
`default_nettype wire

// File: tb/tb_tiled_layer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_tiled_layer
//  Description : Directed self-checking bench for tiled_layer. Main instance:
//                6 neurons / 4 ALUs / 2 inputs (two tiles, partial last tile).
//                Second instance: 4 neurons / 4 ALUs (single tile, ALU_LAT=2).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_tiled_layer;

    localparam int LW = 32 * 4;
    localparam logic [31:0] F1  = 32'h3F800000;
    localparam logic [31:0] F2  = 32'h40000000;
    localparam logic [31:0] F3  = 32'h40400000;
    localparam logic [31:0] F4  = 32'h40800000;
    localparam logic [31:0] F7  = 32'h40E00000;
    localparam logic [31:0] FM1 = 32'hBF800000;
    localparam logic [31:0] FM3 = 32'hC0400000;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // Main instance
    logic          start, in_valid, in_ready, out_valid, out_ready, busy, done;
    logic [31:0]   in_data;
    logic [1:0]    w_addr;
    logic [LW-1:0] w_data, out_data;
    logic [0:0]    out_tile;
    logic [LW-1:0] mem [4];

    tiled_layer #(
        .NUM_NEURONS(6), .NUM_ALUS(4), .NUM_INPUTS(2),
        .BIT_WIDTH(32), .EXTRA_BITS(0), .ALU_LAT(1)
    ) u_dut (
        .CLK(clk), .RESET(rst_n), .START(start),
        .IN_DATA(in_data), .IN_VALID(in_valid), .IN_READY(in_ready),
        .W_ADDR(w_addr), .W_DATA(w_data),
        .OUT_DATA(out_data), .OUT_TILE(out_tile), .OUT_VALID(out_valid), .OUT_READY(out_ready),
        .BUSY(busy), .DONE(done)
    );

    always @(posedge clk) w_data <= mem[w_addr];

    // Single-tile instance
    logic          b_start, b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_busy, b_done;
    logic [31:0]   b_in_data;
    logic [0:0]    b_w_addr;
    logic [LW-1:0] b_w_data, b_out_data;
    logic [0:0]    b_out_tile;
    logic [LW-1:0] b_mem [2];

    tiled_layer #(
        .NUM_NEURONS(4), .NUM_ALUS(4), .NUM_INPUTS(2),
        .BIT_WIDTH(32), .EXTRA_BITS(0), .ALU_LAT(2)
    ) u_dut_b (
        .CLK(clk), .RESET(rst_n), .START(b_start),
        .IN_DATA(b_in_data), .IN_VALID(b_in_valid), .IN_READY(b_in_ready),
        .W_ADDR(b_w_addr), .W_DATA(b_w_data),
        .OUT_DATA(b_out_data), .OUT_TILE(b_out_tile), .OUT_VALID(b_out_valid), .OUT_READY(b_out_ready),
        .BUSY(b_busy), .DONE(b_done)
    );

    always @(posedge clk) b_w_data <= b_mem[b_w_addr];

    int checks = 0;
    int failures = 0;
    int done_cnt = 0;

    always @(negedge clk) if (done === 1'b1) done_cnt++;

    task automatic check(input string tag, input logic [LW-1:0] got, input logic [LW-1:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [LW-1:0] rowv(input logic [31:0] f);
        return {4{f}};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Stream two scalars; vpat bit c is IN_VALID in cycle c (1 after cycle 7)
    task automatic feed(input logic [31:0] x0, input logic [31:0] x1, input logic [7:0] vpat);
        int          n;
        int          cyc;
        bit          fire;
        logic [31:0] xs [2];
        n = 0;
        cyc = 0;
        xs[0] = x0;
        xs[1] = x1;
        while (n < 2 && cyc < 40) begin
            in_valid = (cyc < 8) ? vpat[cyc] : 1'b1;
            in_data  = xs[n];
            #1;
            if (in_valid) check("waddr_issue", LW'(w_addr), LW'(n));
            else if (n > 0) check("waddr_hold", LW'(w_addr), LW'(n - 1));
            fire = in_valid && in_ready;
            tick();
            if (fire) n++;
            cyc++;
        end
        in_valid = 1'b0;
        check("feed_count", LW'(n), LW'(2));
    endtask

    // Wait for a result, optionally stall OUT_READY for 'hold' cycles, then accept
    task automatic get_out(output logic [LW-1:0] d, output logic [0:0] t, input int hold,
                           output bit inrdy_seen);
        int cyc;
        cyc = 0;
        inrdy_seen = 1'b0;
        while (out_valid !== 1'b1 && cyc < 60) begin
            if (in_ready) inrdy_seen = 1'b1;
            tick();
            cyc++;
        end
        check("out_valid_wait", LW'(out_valid), LW'(1));
        d = out_data;
        t = out_tile;
        if (hold > 0) begin
            bit         stable;
            logic [1:0] a0;
            stable = 1'b1;
            a0 = w_addr;
            for (int i = 0; i < hold; i++) begin
                start = (i == 1);
                tick();
                if (out_data !== d || out_tile !== t || out_valid !== 1'b1 || w_addr !== a0) stable = 1'b0;
            end
            start = 1'b0;
            check("hold_stable", LW'(stable), LW'(1));
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic run_eval(input string nm, input logic [31:0] x0, input logic [31:0] x1,
                            input logic [7:0] vpat, input int hold,
                            input logic [LW-1:0] e0, input logic [LW-1:0] e1);
        logic [LW-1:0] d;
        logic [0:0]    t;
        bit            seen;
        start = 1'b1;
        tick();
        start = 1'b0;
        check({nm, "_busy"}, LW'(busy), LW'(1));
        feed(x0, x1, vpat);
        get_out(d, t, hold, seen);
        check({nm, "_t0_data"}, d, e0);
        check({nm, "_t0_tile"}, LW'(t), LW'(0));
        get_out(d, t, 0, seen);
        check({nm, "_t1_data"}, d, e1);
        check({nm, "_t1_tile"}, LW'(t), LW'(1));
        check({nm, "_t1_inready_low"}, LW'(seen), LW'(0));
        check({nm, "_done_pulse"}, LW'(done), LW'(1));
        tick();
        check({nm, "_done_clear"}, LW'(done), LW'(0));
        check({nm, "_idle"}, LW'(busy), LW'(0));
    endtask

    localparam logic [LW-1:0] EXP_T0 = {4{F3}};
    localparam logic [LW-1:0] EXP_T1 = {32'h0, 32'h0, F7, F7};

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1);
    end

    initial begin
        logic [LW-1:0] d;
        logic [0:0]    t;
        bit            seen;
        bit            fire;
        int            n, cyc, dc;

        start = 0; in_valid = 0; in_data = '0; out_ready = 0;
        b_start = 0; b_in_valid = 0; b_in_data = '0; b_out_ready = 0;
        mem[0] = rowv(F1); mem[1] = rowv(F2); mem[2] = rowv(F3); mem[3] = rowv(F4);
        b_mem[0] = rowv(F1); b_mem[1] = rowv(F1);

        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", LW'(out_valid), LW'(0));
        check("rst_busy", LW'(busy), LW'(0));
        check("rst_done", LW'(done), LW'(0));
        check("rst_in_ready", LW'(in_ready), LW'(0));
        check("rst_out_data", out_data, '0);
        check("rst_w_addr", LW'(w_addr), LW'(0));
        check("rst_out_tile", LW'(out_tile), LW'(0));
        rst_n = 1'b1;
        tick();

        // Weights row r = r+1.0, inputs 1.0,1.0: tile0 = 3.0, tile1 = 7.0 on lanes 0-1
        run_eval("gapfree", F1, F1, 8'hFF, 0, EXP_T0, EXP_T1);
        // IN_VALID 1,0,0,1 gives identical results
        run_eval("gaps", F1, F1, 8'hF9, 0, EXP_T0, EXP_T1);
        // OUT_READY stalled 5 cycles with a START pulse inside
        run_eval("stall", F1, F1, 8'hFF, 5, EXP_T0, EXP_T1);

        // Reset during REPLAY
        start = 1'b1;
        tick();
        start = 1'b0;
        feed(F1, F1, 8'hFF);
        get_out(d, t, 0, seen);
        check("replay_addr", LW'(w_addr), LW'(2));
        dc = done_cnt;
        rst_n = 1'b0;
        #1;
        check("mid_rst_busy", LW'(busy), LW'(0));
        check("mid_rst_out_valid", LW'(out_valid), LW'(0));
        check("mid_rst_out_data", out_data, '0);
        check("mid_rst_out_tile", LW'(out_tile), LW'(0));
        check("mid_rst_w_addr", LW'(w_addr), LW'(0));
        check("mid_rst_in_ready", LW'(in_ready), LW'(0));
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (4) tick();
        check("mid_rst_no_done", LW'(done_cnt), LW'(dc));
        check("mid_rst_idle", LW'(busy), LW'(0));
        run_eval("after_rst", F1, F1, 8'hFF, 0, EXP_T0, EXP_T1);

        // Negative accumulations: -1*1 + -1*2 = -3.0 on tile 0
        mem[0] = rowv(FM1); mem[1] = rowv(FM1); mem[2] = rowv(F1); mem[3] = rowv(F1);
`ifdef LAYER_RELU_EN
        run_eval("relu", F1, F2, 8'hFF, 0, '0, {32'h0, 32'h0, F3, F3});
`else
        run_eval("relu", F1, F2, 8'hFF, 0, rowv(FM3), {32'h0, 32'h0, F3, F3});
`endif

        // Single-tile instance: inputs 1.0,2.0, weights 1.0 -> 3.0 on every lane
        b_start = 1'b1;
        tick();
        b_start = 1'b0;
        n = 0;
        cyc = 0;
        while (n < 2 && cyc < 20) begin
            b_in_data  = (n == 0) ? F1 : F2;
            b_in_valid = 1'b1;
            #1;
            fire = b_in_ready;
            tick();
            if (fire) n++;
            cyc++;
        end
        b_in_valid = 1'b0;
        check("b_feed_count", LW'(n), LW'(2));
        cyc = 0;
        while (b_out_valid !== 1'b1 && cyc < 60) begin
            tick();
            cyc++;
        end
        check("b_out_valid_wait", LW'(b_out_valid), LW'(1));
        check("b_data", b_out_data, rowv(F3));
        check("b_tile", LW'(b_out_tile), LW'(0));
        b_out_ready = 1'b1;
        tick();
        b_out_ready = 1'b0;
        check("b_done_pulse", LW'(b_done), LW'(1));
        check("b_idle", LW'(b_busy), LW'(0));
        tick();
        check("b_done_clear", LW'(b_done), LW'(0));
        check("b_no_more_output", LW'(b_out_valid), LW'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
